// File: rtl/gray_to_rgb565_ise.sv
// gray_to_rgb565_ise
// Custom-instruction block that expands packed 8-bit gray pixels into RGB565.
// One LOAD_LO call converts pixels 0,1 and buffers all four gray bytes.
// A following READ_HI call returns pixels 2,3 from that buffer.
// The result bus is zero whenever done is low, so it can be OR-combined
// with the results of other ISEs on the same port.
//
// Build option: define GRAY2RGB_BYTE_SWAP_EN to byte-swap every 16-bit output
// pixel for little-endian framebuffers. Timing and opcodes are unchanged.

module gray_to_rgb565_ise #(
    parameter logic [7:0] customInstructionId = 8'd0
) (
    input  logic        clock,
    input  logic        nReset,
    input  logic        start,
    input  logic [7:0]  iseId,
    input  logic [31:0] valueA,
    input  logic [31:0] valueB,
    output logic        done,
    output logic [31:0] result
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CONVERT = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    localparam logic [1:0] OP_LOAD_LO   = 2'd0;
    localparam logic [1:0] OP_READ_HI   = 2'd1;
    localparam logic [1:0] OP_LOAD_ONLY = 2'd2;
    localparam logic [1:0] OP_CLEAR     = 2'd3;

    // Plain bit replication/truncation: no rounding, no saturation.
    function automatic logic [15:0] gray_to_565(input logic [7:0] g);
        return {g[7:3], g[7:2], g[7:3]};
    endfunction

    // Output pixel formatting; the byte swap serves little-endian framebuffers.
    function automatic logic [15:0] fmt_pixel(input logic [15:0] p);
`ifdef GRAY2RGB_BYTE_SWAP_EN
        return {p[7:0], p[15:8]};
`else
        return p;
`endif
    endfunction

    // Two gray bytes to one 32-bit result word, high pixel in the upper half.
    function automatic logic [31:0] pack_pair(input logic [7:0] g_hi, input logic [7:0] g_lo);
        return {fmt_pixel(gray_to_565(g_hi)), fmt_pixel(gray_to_565(g_lo))};
    endfunction

    state_t      state_r;
    logic [31:0] value_a_r;
    logic [1:0]  opcode_r;
    logic        buf_valid_lat_r;
    logic [31:0] pix_buf_r;
    logic        buf_valid_r;
    logic        done_r;
    logic [31:0] result_r;
    logic [31:0] conv_result_s;
    logic        accept_s;
    logic        unused_value_b_s;

    // Upper opcode-word bits carry no meaning for this instruction.
    assign unused_value_b_s = ^valueB[31:2];

    // Accept only a matching start while idle; other starts are simply dropped.
    assign accept_s = start && (iseId == customInstructionId) && (state_r == ST_IDLE);

    // Result word produced during CONVERT from the latched operands.
    always_comb begin
        conv_result_s = 32'd0;
        case (opcode_r)
            OP_LOAD_LO: begin
                conv_result_s = pack_pair(value_a_r[15:8], value_a_r[7:0]);
            end
            OP_READ_HI: begin
                if (buf_valid_lat_r) begin
                    conv_result_s = pack_pair(pix_buf_r[31:24], pix_buf_r[23:16]);
                end else begin
                    conv_result_s = 32'd0;
                end
            end
            OP_LOAD_ONLY: begin
                conv_result_s = 32'd0;
            end
            OP_CLEAR: begin
                conv_result_s = 32'd0;
            end
            default: begin
                conv_result_s = 32'd0;
            end
        endcase
    end

    // Instruction FSM: latch in IDLE, compute and update buffer in CONVERT,
    // present the registered result for exactly one cycle in DONE.
    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            state_r         <= ST_IDLE;
            value_a_r       <= 32'd0;
            opcode_r        <= 2'd0;
            buf_valid_lat_r <= 1'b0;
            pix_buf_r       <= 32'd0;
            buf_valid_r     <= 1'b0;
            done_r          <= 1'b0;
            result_r        <= 32'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r   <= 1'b0;
                    result_r <= 32'd0;
                    if (accept_s) begin
                        value_a_r       <= valueA;
                        opcode_r        <= valueB[1:0];
                        buf_valid_lat_r <= buf_valid_r;
                        state_r         <= ST_CONVERT;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_CONVERT: begin
                    // Buffer changes land at the end of CONVERT so a READ_HI
                    // accepted right after this instruction sees the new data.
                    case (opcode_r)
                        OP_LOAD_LO, OP_LOAD_ONLY: begin
                            pix_buf_r   <= value_a_r;
                            buf_valid_r <= 1'b1;
                        end
                        OP_CLEAR: begin
                            pix_buf_r   <= 32'd0;
                            buf_valid_r <= 1'b0;
                        end
                        default: begin
                            pix_buf_r   <= pix_buf_r;
                            buf_valid_r <= buf_valid_r;
                        end
                    endcase
                    result_r <= conv_result_s;
                    done_r   <= 1'b1;
                    state_r  <= ST_DONE;
                end
                ST_DONE: begin
                    done_r   <= 1'b0;
                    result_r <= 32'd0;
                    state_r  <= ST_IDLE;
                end
                default: begin
                    done_r   <= 1'b0;
                    result_r <= 32'd0;
                    state_r  <= ST_IDLE;
                end
            endcase
        end
    end

    assign done   = done_r;
    assign result = result_r;

endmodule

// File: doc/gray_to_rgb565_ise.md
# gray_to_rgb565_ise

Custom-instruction block converting packed 8-bit grayscale pixels back into RGB565 for display output; the inverse path of the RGB565-to-grayscale instruction. One call loads four gray pixels from `valueA` and returns two RGB565 pixels. A follow-up call returns the other two from an internal buffer. It sits on the processor's custom-instruction port alongside the other ISEs and uses a registered FSM, with `done` asserted two cycles after `start`.

## Interface
- `customInstructionId`, default 8'd0: ID this block answers to.
- `clock` in 1: system clock, rising edge.
- `nReset` in 1: one clock; reset is asynchronous and active-low.
- `start` in 1: CI start strobe, one cycle.
- `iseId` in 8: selected CI ID.
- `valueA` in 32: four gray pixels; pixel k = `valueA[8k+7:8k]`.
- `valueB` in 32: `valueB[1:0]` is the opcode; `[31:2]` are ignored.
- `done` out 1: one-cycle completion pulse.
- `result` out 32: two RGB565 pixels; lower pixel in `[15:0]`, higher pixel in `[31:16]`.

## Operation
- Accept condition: `start && iseId == customInstructionId` while FSM is IDLE.
  - Accepts in any other state are ignored, with no queueing.
- On accept, the block latches `valueA`, `valueB[1:0]` and the buffer-valid flag `bufValid`.
- Opcodes:
  - 0 LOAD_LO: store all 4 gray bytes in `buf`, set `bufValid`=1, return pixels 0,1 from the latched `valueA`.
  - 1 READ_HI: return pixels 2,3 from `buf` if `bufValid`, else result 0x0000_0000. The buffer is unchanged.
  - 2 LOAD_ONLY: store `buf`, set `bufValid`=1, result 0.
  - 3 CLEAR: `bufValid`=0, `buf`=0, result 0.
- Conversion per pixel, gray g[7:0]:
  - R5 = g[7:3], G6 = g[7:2], B5 = g[7:3].
  - Pixel = {R5, G6, B5}.
  - Truncation only; no rounding and no saturation logic.
- FSM: IDLE -> CONVERT -> DONE -> IDLE.
  - IDLE: waits for accept, latches inputs.
  - CONVERT: computes both pixels into `resultReg`, applies buffer writes.
  - DONE: drives `done`=1 and `result`=`resultReg`, then returns to IDLE.
- `result` is forced to 0 whenever `done`=0, so it can be OR-combined with other ISEs.
- Back-to-back: a new accept is possible in the IDLE cycle immediately after DONE.
  - READ_HI sees the buffer written by an earlier LOAD_LO.

## Timing
- Reset, asynchronous, asserted low. While `nReset`=0:
  - FSM=IDLE, `done`=0, `result`=0.
  - `buf`=0, `bufValid`=0, all latches 0.
- Reset mid-operation aborts the instruction. No `done` is produced, and the buffer is cleared.
- Latency: accept on rising edge T gives CONVERT in cycle T+1 and `done`=1 for exactly cycle T+2.
- Throughput: one instruction per 3 cycles.
- `start` pulses during CONVERT or DONE, for any ID, have no effect on state or outputs.
- The buffer update from LOAD_LO or LOAD_ONLY takes effect at the end of CONVERT. An immediately following READ_HI therefore returns the new data.

## Configuration
- `GRAY2RGB_BYTE_SWAP_EN`:
  - Defined: each 16-bit output pixel is byte-swapped (`{p[7:0], p[15:8]}`) for little-endian framebuffer writes.
  - Undefined: pixels are output as {R5,G6,B5} unchanged.
- The macro affects only `result` formatting. Timing and opcode behaviour are identical in both builds.

## Test plan
- Reset, then LOAD_LO with `valueA`=0x7F00_80FF -> `done` at T+2, `result`=0x8410_FFFF (swap build: 0x1084_FFFF).
- Then READ_HI -> `result`=0x7BEF_0000 (swap build: 0xEF7B_0000); `done` one cycle wide.
- READ_HI after reset, or after CLEAR -> `done` at T+2, `result`=0x0000_0000.
- `start` with `iseId`≠`customInstructionId` -> no `done`, `result` stays 0.
  - A second matching `start` during CONVERT is ignored: exactly one `done`.
- LOAD_ONLY `valueA`=0xFFFF_FFFF, then READ_HI -> `result`=0xFFFF_FFFF.
  - `result` was 0 for the LOAD_ONLY call itself.
- Assert `nReset` low during CONVERT of a LOAD_LO -> no `done`, `result`=0.
  - A subsequent READ_HI returns 0, because the buffer was cleared.
